carry_select_adder: RTL and testbench



---
 rtl/carry_select_adder_if.sv | 18 +
 rtl/carry_select_adder.sv | 84 ++++++++
 tb/tb_carry_select_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/carry_select_adder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | carry_select_adder_if : operand/result bundle for the adder       |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface carry_select_adder_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c0;
  logic [WIDTH-1:0] sum;
  logic             c6;

  modport master (output A, output B, output c0, input sum, input c6);
  modport slave  (input A, input B, input c0, output sum, output c6);
endinterface
`default_nettype wire

// File: rtl/carry_select_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | carry_select_adder : carry-select adder, registered sum/carry-out |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module carry_select_adder #(
  parameter int WIDTH = 6,
  parameter int BLK   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  carry_select_adder_if.slave  bus
);

  localparam int NBLK = WIDTH / BLK;

  function automatic logic [BLK:0] ripple(
    input logic [BLK-1:0] a,
    input logic [BLK-1:0] b,
    input logic           ci
  );
    logic           c;
    logic [BLK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < BLK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             c6_d;
  logic             c6_q;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLK-1:0] w_a;
    logic [BLK-1:0] w_b;
    logic           w_cout;

    assign w_a = bus.A[k*BLK +: BLK];
    assign w_b = bus.B[k*BLK +: BLK];

    if (k == 0) begin : g_ripple
      logic [BLK:0] w_r;
      assign w_r                 = ripple(w_a, w_b, bus.c0);
      assign w_sum[k*BLK +: BLK] = w_r[BLK-1:0];
      assign w_cout              = w_r[BLK];
    end else begin : g_select
      logic [BLK:0] w_r0;
      logic [BLK:0] w_r1;
      logic         w_sel;
      // Both carry-in hypotheses are ready before the lower block resolves.
      assign w_r0                = ripple(w_a, w_b, 1'b0);
      assign w_r1                = ripple(w_a, w_b, 1'b1);
      assign w_sel               = g_blk[k-1].w_cout;
      assign w_sum[k*BLK +: BLK] = w_sel ? w_r1[BLK-1:0] : w_r0[BLK-1:0];
      assign w_cout              = w_sel ? w_r1[BLK] : w_r0[BLK];
    end
  end

  always_comb begin
    sum_d = w_sum;
    c6_d  = g_blk[NBLK-1].w_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      c6_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      c6_q  <= c6_d;
    end
  end

  assign bus.sum = sum_q;
  assign bus.c6  = c6_q;

endmodule
`default_nettype wire

// File: tb/tb_carry_select_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_carry_select_adder : randomized + exhaustive check vs A+B+c0   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_carry_select_adder;

  localparam int WIDTH = 6;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [WIDTH:0] model_q;

  carry_select_adder_if #(.WIDTH(WIDTH)) bus ();

  carry_select_adder #(.WIDTH(WIDTH), .BLK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one-cycle-delayed plain integer sum, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_q <= '0;
    else        model_q <= {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.c0};
  end

  task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {c6,sum}=%b required %b at %0t", name, act, req, $time);
    end
  endtask

  // Continuous compare against the model on every falling edge.
  always @(negedge clk) begin
    check("model", {bus.c6, bus.sum}, model_q);
  end

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    bus.A  = a;
    bus.B  = b;
    bus.c0 = c;
  endtask

  task automatic directed(input string name, input logic c, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] s, input logic co);
    @(posedge clk);
    #2 drive(a, b, c);
    @(posedge clk);
    #1 check(name, {bus.c6, bus.sum}, {co, s});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(6'd63, 6'd63, 1'b1);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_immediate", {bus.c6, bus.sum}, 7'd0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", {bus.c6, bus.sum}, 7'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release_max", {bus.c6, bus.sum}, {1'b1, 6'd63});

    directed("top_carry",     1'b1, 6'b100000, 6'b100000, 6'b000001, 1'b1);
    directed("mixed_c1",      1'b1, 6'b101001, 6'b001100, 6'b110110, 1'b0);
    directed("all_ones_c1",   1'b1, 6'b100110, 6'b011000, 6'b111111, 1'b0);
    directed("full_ripple",   1'b1, 6'b101010, 6'b010101, 6'b000000, 1'b1);
    directed("alt_c0",        1'b0, 6'b010101, 6'b101010, 6'b111111, 1'b0);
    directed("top_only",      1'b0, 6'b100000, 6'b100000, 6'b000000, 1'b1);
    directed("all_ones_c0",   1'b0, 6'b100110, 6'b011001, 6'b111111, 1'b0);
    directed("wrap_c0",       1'b0, 6'b010110, 6'b101010, 6'b000000, 1'b1);
    directed("min_case",      1'b0, 6'd0,      6'd0,      6'd0,      1'b0);
    directed("max_case",      1'b1, 6'd63,     6'd63,     6'd63,     1'b1);

    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2 drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    // Mid-operation reset discards the in-flight result at once.
    @(posedge clk);
    #2 drive(6'd40, 6'd30, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_op", {bus.c6, bus.sum}, 7'd0);
    drive(6'd17, 6'd9, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_mid_release", {bus.c6, bus.sum}, 7'd26);

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(posedge clk);
          #2 drive(WIDTH'(a), WIDTH'(b), 1'(c));
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
